// File: rtl/conv_mem_arbiter.sv
// conv_mem_arbiter: round-robin sharing of the single layer-memory port
// among the CNN engines, with burst lock and forced lock release.
module conv_mem_arbiter #(
    parameter int N_REQ    = 3,
    parameter int AW       = 12,
    parameter int DW       = 20,
    parameter int SW       = 3,
    parameter int LOCK_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ-1:0]    req_lock,
    input  logic [SW*N_REQ-1:0] req_sel,
    input  logic [AW*N_REQ-1:0] req_addr,
    input  logic [DW*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                lock_tmo,
    output logic                busy,
    output logic                crd,
    output logic                cwr,
    output logic [SW-1:0]       csel,
    output logic [AW-1:0]       caddr_rd,
    output logic [AW-1:0]       caddr_wr,
    output logic [DW-1:0]       cdata_wr,
    input  logic [DW-1:0]       cdata_rd
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nx;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   w_owner_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [PW-1:0]   w_idx;
    logic [N_REQ-1:0] w_gnt;
    logic            w_tmo;
    logic            w_xfer;
    logic            w_we;
    logic [SW-1:0]   w_sel;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;

    logic             r_crd;
    logic             r_cwr;
    logic [SW-1:0]    r_csel;
    logic [AW-1:0]    r_caddr_rd;
    logic [AW-1:0]    r_caddr_wr;
    logic [DW-1:0]    r_cdata_wr;
    logic [PW-1:0]    r_rd_id;
    logic [N_REQ-1:0] r_rvalid;
    logic [DW-1:0]    r_rdata;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] v);
        return (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        w_gnt      = '0;
        w_tmo      = 1'b0;
        w_idx      = r_owner;
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_owner_nx = r_owner;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            ARB: begin
                // Scan backwards so the nearest requester from ptr wins last.
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    if (req[(int'(r_ptr) + k) % N_REQ])
                        w_idx = PW'((int'(r_ptr) + k) % N_REQ);
                end
                if (|req) begin
                    w_gnt[w_idx] = 1'b1;
                    if (req_lock[w_idx]) begin
                        w_owner_nx = w_idx;
                        w_cnt_nx   = CW'(1);
                        w_state_nx = LOCKED;
                    end else begin
                        w_ptr_nx = inc(w_idx);
                    end
                end
            end
            LOCKED: begin
                if (r_cnt == CW'(LOCK_MAX)) begin
                    w_tmo      = 1'b1;
                    w_ptr_nx   = inc(r_owner);
                    w_cnt_nx   = '0;
                    w_state_nx = ARB;
                end else begin
                    w_cnt_nx       = r_cnt + 1'b1;
                    w_gnt[r_owner] = req[r_owner];
                    if (req[r_owner] && !req_lock[r_owner]) begin
                        w_ptr_nx   = inc(r_owner);
                        w_cnt_nx   = '0;
                        w_state_nx = ARB;
                    end
                end
            end
        endcase
    end

    assign w_xfer  = |w_gnt;
    assign w_we    = req_we[w_idx];
    assign w_sel   = req_sel[SW*w_idx +: SW];
    assign w_addr  = req_addr[AW*w_idx +: AW];
    assign w_wdata = req_wdata[DW*w_idx +: DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ARB;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_cnt      <= '0;
            r_crd      <= 1'b0;
            r_cwr      <= 1'b0;
            r_csel     <= '0;
            r_caddr_rd <= '0;
            r_caddr_wr <= '0;
            r_cdata_wr <= '0;
            r_rd_id    <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_owner <= w_owner_nx;
            r_cnt   <= w_cnt_nx;
            r_crd   <= w_xfer & ~w_we;
            r_cwr   <= w_xfer & w_we;
            r_csel  <= w_xfer ? w_sel : '0;
            if (w_xfer && !w_we) begin
                r_caddr_rd <= w_addr;
                r_rd_id    <= w_idx;
            end
            if (w_xfer && w_we) begin
                r_caddr_wr <= w_addr;
                r_cdata_wr <= w_wdata;
            end
            // Memory answers during the crd cycle; return it to the issuer.
            r_rvalid <= '0;
            if (r_crd) begin
                r_rvalid[r_rd_id] <= 1'b1;
                r_rdata           <= cdata_rd;
            end
        end
    end

    assign gnt      = reset ? '0 : w_gnt;
    assign lock_tmo = ~reset & w_tmo;
    assign busy     = ~reset & (|req | r_crd | r_cwr | |r_rvalid);
    assign crd      = r_crd;
    assign cwr      = r_cwr;
    assign csel     = r_csel;
    assign caddr_rd = r_caddr_rd;
    assign caddr_wr = r_caddr_wr;
    assign cdata_wr = r_cdata_wr;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Bench for conv_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration and memory model.
module tb_conv_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 20;
    localparam int SW = 3;
    localparam int LM = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, req_we, req_lock;
    logic [SW*N-1:0] req_sel;
    logic [AW*N-1:0] req_addr;
    logic [DW*N-1:0] req_wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, cdata_wr, cdata_rd;
    logic            lock_tmo, busy, crd, cwr;
    logic [SW-1:0]   csel;
    logic [AW-1:0]   caddr_rd, caddr_wr;

    always #5 clk = ~clk;

    conv_mem_arbiter #(
        .N_REQ(N), .AW(AW), .DW(DW), .SW(SW), .LOCK_MAX(LM)
    ) dut (
        .clk(clk), .reset(reset),
        .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .lock_tmo(lock_tmo), .busy(busy),
        .crd(crd), .cwr(cwr), .csel(csel),
        .caddr_rd(caddr_rd), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
    );

    // requester-side commands
    logic          rq_v  [N];
    logic          rq_we [N];
    logic          rq_lk [N];
    logic [SW-1:0] rq_sel[N];
    logic [AW-1:0] rq_ad [N];
    logic [DW-1:0] rq_wd [N];

    // layer memory and its reference image
    logic [DW-1:0] mem  [int];
    logic [DW-1:0] refm [int];

    // model state
    int            m_ptr, m_owner, m_cnt;
    bit            m_lk;
    logic [N-1:0]  e_g, e_rv, o_gnt;
    logic          e_tmo, o_tmo, o_busy, e_crd, e_cwr;
    logic [SW-1:0] e_csel;
    logic [AW-1:0] e_ard, e_awr;
    logic [DW-1:0] e_wd, e_rdata, p_d;
    bit            p_v;
    int            p_id;
    int            n_vec, n_err;

    function automatic int key(input logic [SW-1:0] s, input logic [AW-1:0] a);
        return int'({s, a});
    endfunction

    function automatic logic [DW-1:0] dflt(input int k);
        return DW'((k * 40503) ^ 32'h5A5A5);
    endfunction

    function automatic logic [DW-1:0] rd_mem(input int k);
        return mem.exists(k) ? mem[k] : dflt(k);
    endfunction

    function automatic logic [DW-1:0] rd_ref(input int k);
        return refm.exists(k) ? refm[k] : dflt(k);
    endfunction

    // memory acts mid-cycle: commit writes, present read data
    always @(negedge clk) begin
        if (cwr) mem[key(csel, caddr_wr)] = cdata_wr;
        cdata_rd = crd ? rd_mem(key(csel, caddr_rd)) : '0;
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]                 = rq_v[i];
            req_we[i]              = rq_we[i];
            req_lock[i]            = rq_lk[i];
            req_sel[SW*i +: SW]    = rq_sel[i];
            req_addr[AW*i +: AW]   = rq_ad[i];
            req_wdata[DW*i +: DW]  = rq_wd[i];
        end
    endtask

    task automatic set_cmd(input int i, input bit we, input bit lk,
                           input int sel, input int ad, input logic [DW-1:0] wd);
        rq_v[i]   = 1'b1;
        rq_we[i]  = we;
        rq_lk[i]  = lk;
        rq_sel[i] = SW'(sel);
        rq_ad[i]  = AW'(ad);
        rq_wd[i]  = wd;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_lk = 0;
        e_rv = '0; e_crd = 0; e_cwr = 0; e_csel = '0;
        e_ard = '0; e_awr = '0; e_wd = '0; e_rdata = '0;
        p_v = 0; p_id = 0; p_d = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
        drive();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: drive, sample comb outputs, advance model, sample after edge.
    task automatic cycle();
        int w;
        int k;
        @(negedge clk);
        drive();
        #1;
        o_gnt  = gnt;
        o_tmo  = lock_tmo;
        o_busy = busy;
        w      = -1;
        e_g    = '0;
        e_tmo  = 1'b0;
        if (m_lk) begin
            if (m_cnt >= LM) e_tmo = 1'b1;
            else if (rq_v[m_owner]) w = m_owner;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (w < 0 && rq_v[(m_ptr + j) % N]) w = (m_ptr + j) % N;
            end
        end
        if (w >= 0) e_g[w] = 1'b1;
        if (e_tmo) begin
            m_lk  = 0;
            m_ptr = (m_owner + 1) % N;
        end else if (m_lk) begin
            m_cnt = (m_cnt + 1 > LM) ? LM : m_cnt + 1;
            if (w >= 0 && !rq_lk[w]) begin
                m_lk  = 0;
                m_ptr = (w + 1) % N;
            end
        end else if (w >= 0) begin
            if (rq_lk[w]) begin
                m_lk = 1; m_owner = w; m_cnt = 1;
            end else begin
                m_ptr = (w + 1) % N;
            end
        end
        e_rv = '0;
        if (p_v) begin
            e_rv[p_id] = 1'b1;
            e_rdata    = p_d;
        end
        p_v = 0; e_crd = 0; e_cwr = 0; e_csel = '0;
        if (w >= 0) begin
            k      = key(rq_sel[w], rq_ad[w]);
            e_csel = rq_sel[w];
            if (rq_we[w]) begin
                e_cwr   = 1'b1;
                e_awr   = rq_ad[w];
                e_wd    = rq_wd[w];
                refm[k] = rq_wd[w];
            end else begin
                e_crd = 1'b1;
                e_ard = rq_ad[w];
                p_v   = 1; p_id = w; p_d = rd_ref(k);
            end
            rq_v[w] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_cmd(1, 0, 0, 1, 3, '0);
        drive();
        reset = 1'b1;
        #1;
        n_vec++;
        if ({gnt, rvalid, crd, cwr, lock_tmo, busy} !== '0 ||
            {csel, caddr_rd, caddr_wr, cdata_wr, rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_state gnt=%b rv=%b crd=%b cwr=%b busy=%b csel=%0d want all 0",
                     gnt, rvalid, crd, cwr, busy, csel);
        end
        #1;
        reset = 1'b0;
        rq_v[1] = 1'b0;
        drive();
        model_reset();
        set_cmd(0, 0, 0, 2, 7, '0);
        cycle();
        n_vec++;
        if (crd !== 1'b1 || caddr_rd !== 12'h007) begin
            n_err++;
            $display("FAIL reset_pre crd=%b addr=%h want crd=1 addr=007", crd, caddr_rd);
        end
        set_cmd(2, 0, 0, 1, 9, '0);
        drive();
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if ({gnt, rvalid, crd, cwr, lock_tmo, busy, csel} !== '0 ||
            caddr_rd !== '0 || rdata !== '0) begin
            n_err++;
            $display("FAIL reset_mid gnt=%b crd=%b busy=%b csel=%0d addr=%h want all 0",
                     gnt, crd, busy, csel, caddr_rd);
        end
        #1 reset = 1'b0;
        for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
        drive();
        model_reset();
        repeat (4) begin
            cycle();
            n_vec++;
            if (rvalid !== '0 || crd !== 1'b0) begin
                n_err++;
                $display("FAIL reset_discard rvalid=%b crd=%b want 000/0", rvalid, crd);
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++)
                if (!rq_v[i]) set_cmd(i, 0, 0, i + 1, 'h100 + i, '0);
            cycle();
            n_vec++;
            if (o_gnt !== (N'(1) << (k % 3)) || csel !== SW'(k % 3 + 1) ||
                caddr_rd !== AW'('h100 + k % 3)) begin
                n_err++;
                $display("FAIL rr k=%0d gnt=%b csel=%0d addr=%h want gnt=%b csel=%0d",
                         k, o_gnt, csel, caddr_rd, N'(1) << (k % 3), k % 3 + 1);
            end
        end
    endtask

    task automatic test_read_latency();
        apply_reset();
        mem[key(3'd1, 12'h041)]  = 20'h0A89E;
        refm[key(3'd1, 12'h041)] = 20'h0A89E;
        set_cmd(0, 0, 0, 1, 'h041, '0);
        cycle();
        n_vec++;
        if (o_gnt !== 3'b001 || crd !== 1'b1 || cwr !== 1'b0 ||
            csel !== 3'd1 || caddr_rd !== 12'h041 || rvalid !== '0) begin
            n_err++;
            $display("FAIL lat_t1 gnt=%b crd=%b csel=%0d addr=%h rv=%b want 001/1/1/041/000",
                     o_gnt, crd, csel, caddr_rd, rvalid);
        end
        cycle();
        n_vec++;
        if (rvalid !== 3'b001 || rdata !== 20'h0A89E || crd !== 1'b0) begin
            n_err++;
            $display("FAIL lat_t2 rv=%b rdata=%h crd=%b want 001/0A89E/0",
                     rvalid, rdata, crd);
        end
        cycle();
        n_vec++;
        if (rvalid !== '0) begin
            n_err++;
            $display("FAIL lat_t3 rv=%b want 000", rvalid);
        end
    endtask

    task automatic test_pool_burst();
        apply_reset();
        for (int b = 0; b < 5; b++) begin
            if (b < 4) set_cmd(1, 0, 1, 3, 'h20 + b, '0);
            else       set_cmd(1, 1, 0, 3, 5, DW'($urandom));
            if (b >= 1) begin
                if (!rq_v[0]) set_cmd(0, 0, 0, 1, 1, '0);
                if (!rq_v[2]) set_cmd(2, 0, 0, 2, 2, '0);
            end
            cycle();
            n_vec++;
            if (o_gnt !== 3'b010) begin
                n_err++;
                $display("FAIL pool_beat b=%0d gnt=%b want 010", b, o_gnt);
            end
        end
        n_vec++;
        if (cwr !== 1'b1 || crd !== 1'b0 || caddr_wr !== 12'd5 || csel !== 3'd3) begin
            n_err++;
            $display("FAIL pool_write cwr=%b addr=%h csel=%0d want 1/005/3",
                     cwr, caddr_wr, csel);
        end
        cycle();
        n_vec++;
        if (o_gnt !== 3'b100) begin
            n_err++;
            $display("FAIL pool_next gnt=%b want 100", o_gnt);
        end
    endtask

    task automatic test_lock_timeout();
        apply_reset();
        set_cmd(0, 0, 1, 1, 'h30, '0);
        cycle();
        n_vec++;
        if (o_gnt !== 3'b001) begin
            n_err++;
            $display("FAIL tmo_lock gnt=%b want 001", o_gnt);
        end
        set_cmd(1, 0, 0, 2, 'h31, '0);
        set_cmd(2, 0, 0, 3, 'h32, '0);
        for (int k = 1; k <= LM; k++) begin
            cycle();
            n_vec++;
            if (o_gnt !== '0 || o_tmo !== (k == LM)) begin
                n_err++;
                $display("FAIL tmo_wait k=%0d gnt=%b tmo=%b want 000/%0d",
                         k, o_gnt, o_tmo, k == LM);
            end
        end
        cycle();
        n_vec++;
        if (o_gnt !== 3'b010 || o_tmo !== 1'b0 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_after gnt=%b tmo=%b busy=%b want 010/0/1",
                     o_gnt, o_tmo, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_cmd(2, 1, 0, 2, 'h123, 20'hF7295);
        cycle();
        n_vec++;
        if (o_gnt !== 3'b100 || cwr !== 1'b1 || crd !== 1'b0 ||
            caddr_wr !== 12'h123 || cdata_wr !== 20'hF7295) begin
            n_err++;
            $display("FAIL b2b_wr gnt=%b cwr=%b addr=%h data=%h want 100/1/123/F7295",
                     o_gnt, cwr, caddr_wr, cdata_wr);
        end
        set_cmd(2, 0, 0, 2, 'h123, '0);
        cycle();
        n_vec++;
        if (o_gnt !== 3'b100 || crd !== 1'b1 || cwr !== 1'b0 || caddr_rd !== 12'h123) begin
            n_err++;
            $display("FAIL b2b_rd gnt=%b crd=%b cwr=%b addr=%h want 100/1/0/123",
                     o_gnt, crd, cwr, caddr_rd);
        end
        cycle();
        n_vec++;
        if (rvalid !== 3'b100 || rdata !== 20'hF7295) begin
            n_err++;
            $display("FAIL b2b_ret rv=%b rdata=%h want 100/F7295", rvalid, rdata);
        end
        repeat (3) cycle();
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_busy busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_random(input int ncyc);
        apply_reset();
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rq_v[i] && $urandom_range(0, 99) < 45)
                    set_cmd(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                            $urandom_range(1, 7), $urandom_range(0, 15), DW'($urandom));
            end
            cycle();
            n_vec++;
            if (o_gnt !== e_g || o_tmo !== e_tmo) begin
                n_err++;
                $display("FAIL rnd_gnt c=%0d gnt=%b tmo=%b want %b/%b",
                         c, o_gnt, o_tmo, e_g, e_tmo);
            end
            n_vec++;
            if ({crd, cwr, csel} !== {e_crd, e_cwr, e_csel}) begin
                n_err++;
                $display("FAIL rnd_cmd c=%0d crd=%b cwr=%b csel=%0d want %b/%b/%0d",
                         c, crd, cwr, csel, e_crd, e_cwr, e_csel);
            end
            n_vec++;
            if (caddr_rd !== e_ard || caddr_wr !== e_awr || cdata_wr !== e_wd) begin
                n_err++;
                $display("FAIL rnd_addr c=%0d ard=%h awr=%h wd=%h want %h/%h/%h",
                         c, caddr_rd, caddr_wr, cdata_wr, e_ard, e_awr, e_wd);
            end
            n_vec++;
            if (rvalid !== e_rv || rdata !== e_rdata) begin
                n_err++;
                $display("FAIL rnd_ret c=%0d rv=%b rdata=%h want %b/%h",
                         c, rvalid, rdata, e_rv, e_rdata);
            end
            if (|req) begin
                n_vec++;
                if (o_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL rnd_busy c=%0d busy=%b want 1", c, o_busy);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            rq_v[i] = 1'b0; rq_we[i] = 1'b0; rq_lk[i] = 1'b0;
            rq_sel[i] = '0; rq_ad[i] = '0; rq_wd[i] = '0;
        end
        drive();
        cdata_rd = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_round_robin();
        test_read_latency();
        test_pool_burst();
        test_lock_timeout();
        test_back_to_back();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
